// File: rtl/dual_port_mem.sv
// dual_port_mem: true dual-port RAM with a built-in clear engine; DUAL_PORT_MEM_BYPASS_EN selects write-first reads.
// Latency: 1-cycle registered read on both ports; clear runs 2^ADDR_WIDTH cycles after reset or clear_req.
// Backpressure: none; port accesses are ignored and outputs read 0 while busy is high.
module dual_port_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_we,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    output logic [DATA_WIDTH-1:0] b_q,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic                    accept;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   a_rd;
    logic [DATA_WIDTH-1:0]   b_rd;

    assign accept  = (state == READY) && !clear_req;
    assign collide = a_we && b_we && (a_addr == b_addr);

`ifdef DUAL_PORT_MEM_BYPASS_EN
    // Later assignments take priority so port A data wins on a collision.
    always_comb begin
        a_rd = mem[a_addr];
        if (b_we && (b_addr == a_addr)) a_rd = b_data;
        if (a_we) a_rd = a_data;
        b_rd = mem[b_addr];
        if (b_we) b_rd = b_data;
        if (a_we && (a_addr == b_addr)) b_rd = a_data;
    end
`else
    always_comb begin
        a_rd = mem[a_addr];
        b_rd = mem[b_addr];
    end
`endif

    // Storage has no reset; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (accept) begin
            if (b_we && !collide) mem[b_addr] <= b_data;
            if (a_we) mem[a_addr] <= a_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    a_q      <= '0;
                    b_q      <= '0;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        a_q   <= '0;
                        b_q   <= '0;
                    end else begin
                        a_q <= a_rd;
                        b_q <= b_rd;
                    end
                end
            endcase
        end
    end

endmodule
